// File: rtl/sar_pkg.sv
// sar_pkg
// Shared types and constants for the SAR ADC controller family.
//   sar_state_t : controller state encoding (IDLE, SAMPLE, CONV, DONE)
//   SAR_MAX_*   : upper bounds for the WIDTH / NCH / SAMPLE_CYCLES parameters
//   sar_chw()   : channel address width for a given channel count (never below 1)
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CONV   = 2'd2,
    DONE   = 2'd3
  } sar_state_t;

  localparam int SAR_MAX_WIDTH         = 16;
  localparam int SAR_MAX_NCH           = 16;
  localparam int SAR_MAX_SAMPLE_CYCLES = 255;

  // A single-channel build still needs a 1-bit mux address so ports never collapse to zero width.
  function automatic int sar_chw(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/sar_bit_search.sv
// sar_bit_search
// Binary-search datapath of the SAR controller: a one-hot trial bit walking
// from MSB to LSB and the partial result accumulated from comparator decisions.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low clear (the parent also folds abort into it)
//   init       : load trial = MSB, partial = 0 (start of a conversion)
//   step       : consume one comparator decision and advance one bit
//   cmp        : comparator, 1 = input >= current dac_code
//   dac_code   : code presented to the DAC (partial | trial), 0 when idle
//   last_bit   : the trial bit currently under test is the LSB
//   final_code : the completed result, valid in the cycle last_bit is high
module sar_bit_search #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             step,
  input  logic             cmp,
  output logic [WIDTH-1:0] dac_code,
  output logic             last_bit,
  output logic [WIDTH-1:0] final_code
);

  logic [WIDTH-1:0] r_trial;
  logic [WIDTH-1:0] r_partial;

  // After the LSB decision both registers are cleared so the DAC code
  // returns to zero by itself outside of the conversion window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_trial   <= '0;
      r_partial <= '0;
    end else if (init) begin
      r_trial   <= {1'b1, {(WIDTH-1){1'b0}}};
      r_partial <= '0;
    end else if (step) begin
      if (r_trial[0]) begin
        r_trial   <= '0;
        r_partial <= '0;
      end else begin
        if (cmp) begin
          r_partial <= r_partial | r_trial;
        end
        r_trial <= r_trial >> 1;
      end
    end
  end

  assign dac_code   = r_partial | r_trial;
  assign last_bit   = r_trial[0];
  assign final_code = cmp ? (r_partial | r_trial) : r_partial;

endmodule

// File: rtl/sar_ctrl_mc.sv
// sar_ctrl_mc
// Multi-channel successive-approximation ADC controller. Samples one channel
// (or scans all channels) for SAMPLE_CYCLES, runs a WIDTH-bit binary search
// against the comparator, then presents the result with its channel tag and a
// one-cycle eoc strobe.
// Optional feature macro: SAR_SCAN_EN (adds the scan port and channel scanning).
// Ports:
//   clk, rst_n      : clock and synchronous active-low reset
//   start           : conversion request, accepted only in IDLE
//   abort           : return to IDLE next edge, no result
//   scan            : scan channels 0..NCH-1 (SAR_SCAN_EN builds only)
//   ch_sel          : single-conversion channel, clamped to NCH-1
//   cmp             : comparator, 1 = input >= dac
//   sample          : sample-and-hold control
//   ch              : analog mux address
//   dac             : DAC code
//   busy, eoc       : activity flag, end-of-conversion strobe
//   result          : last completed result
//   result_ch       : channel of result
module sar_ctrl_mc
  import sar_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NCH           = 4,
  parameter int SAMPLE_CYCLES = 1,
  localparam int CHW          = sar_chw(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
`ifdef SAR_SCAN_EN
  input  logic             scan,
`endif
  input  logic [CHW-1:0]   ch_sel,
  input  logic             cmp,
  output logic             sample,
  output logic [CHW-1:0]   ch,
  output logic [WIDTH-1:0] dac,
  output logic             busy,
  output logic             eoc,
  output logic [WIDTH-1:0] result,
  output logic [CHW-1:0]   result_ch
);

  localparam logic [7:0]     CNT_LAST = 8'(SAMPLE_CYCLES - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(NCH - 1);

  sar_state_t       r_state;
  sar_state_t       w_nextState;
  logic [7:0]       r_sampleCnt;
  logic [CHW-1:0]   r_ch;
  logic [WIDTH-1:0] r_result;
  logic [CHW-1:0]   r_resultCh;
  logic             r_sample;
  logic             r_busy;
  logic             r_eoc;
  logic             w_accept;
  logic             w_init;
  logic             w_step;
  logic             w_scanMore;
  logic [CHW-1:0]   w_chStart;
  logic [WIDTH-1:0] w_dacCode;
  logic             w_lastBit;
  logic [WIDTH-1:0] w_finalCode;

  // Out-of-range requests land on the highest real channel.
  assign w_chStart = (int'(ch_sel) >= NCH) ? CH_LAST : ch_sel;

`ifdef SAR_SCAN_EN
  logic r_scan;
  assign w_scanMore = r_scan && (r_ch < CH_LAST);
`else
  assign w_scanMore = 1'b0;
`endif

  // Abort is folded into the datapath clear so the DAC code drops to zero
  // on the same edge the FSM returns to IDLE.
  sar_bit_search #(.WIDTH(WIDTH)) u_search (
    .clk        (clk),
    .rst_n      (rst_n && !abort),
    .init       (w_init),
    .step       (w_step),
    .cmp        (cmp),
    .dac_code   (w_dacCode),
    .last_bit   (w_lastBit),
    .final_code (w_finalCode)
  );

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_init      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = SAMPLE;
          w_accept    = 1'b1;
        end
      end
      SAMPLE: begin
        if (r_sampleCnt == CNT_LAST) begin
          w_nextState = CONV;
          w_init      = 1'b1;
        end
      end
      CONV: begin
        w_step = 1'b1;
        if (w_lastBit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = w_scanMore ? SAMPLE : IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (abort) begin
      w_nextState = IDLE;
      w_accept    = 1'b0;
      w_init      = 1'b0;
      w_step      = 1'b0;
    end
  end

  // Status outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sampleCnt <= '0;
      r_ch        <= '0;
      r_result    <= '0;
      r_resultCh  <= '0;
      r_sample    <= 1'b0;
      r_busy      <= 1'b0;
      r_eoc       <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_sample <= (w_nextState == SAMPLE);
      r_busy   <= (w_nextState != IDLE);
      r_eoc    <= (w_nextState == DONE);
      if (r_state == SAMPLE) begin
        r_sampleCnt <= r_sampleCnt + 8'd1;
      end else begin
        r_sampleCnt <= '0;
      end
      if (w_accept) begin
`ifdef SAR_SCAN_EN
        r_ch <= scan ? '0 : w_chStart;
`else
        r_ch <= w_chStart;
`endif
      end
`ifdef SAR_SCAN_EN
      else if ((r_state == DONE) && (w_nextState == SAMPLE)) begin
        r_ch <= r_ch + 1'b1;
      end
`endif
      if ((r_state == CONV) && (w_nextState == DONE)) begin
        r_result   <= w_finalCode;
        r_resultCh <= r_ch;
      end
    end
  end

`ifdef SAR_SCAN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan <= 1'b0;
    end else if (w_accept) begin
      r_scan <= scan;
    end
  end
`endif

  assign sample    = r_sample;
  assign ch        = r_ch;
  assign dac       = w_dacCode;
  assign busy      = r_busy;
  assign eoc       = r_eoc;
  assign result    = r_result;
  assign result_ch = r_resultCh;

endmodule

// File: tb/tb_sar_ctrl_mc.sv
// tb_sar_ctrl_mc
// Self-checking bench for sar_ctrl_mc (WIDTH=8, NCH=5, SAMPLE_CYCLES=3).
// A comparator model holds one analog code per channel; expected cycle-by-cycle
// behaviour is derived from the binary-search definition and the conversion
// timeline. Scan checks are included when SAR_SCAN_EN is defined.
module tb_sar_ctrl_mc;

  localparam int W   = 8;
  localparam int NCH = 5;
  localparam int SC  = 3;
  localparam int CHW = 3;

  logic           clk    = 1'b0;
  logic           rst_n  = 1'b0;
  logic           start  = 1'b0;
  logic           abort  = 1'b0;
  logic           scan   = 1'b0;
  logic [CHW-1:0] ch_sel = '0;
  logic           cmp;
  logic           sample;
  logic [CHW-1:0] ch;
  logic [W-1:0]   dac;
  logic           busy;
  logic           eoc;
  logic [W-1:0]   result;
  logic [CHW-1:0] result_ch;

  logic [W-1:0]   analog [NCH];
  logic [W-1:0]   expResult   = '0;
  logic [CHW-1:0] expResultCh = '0;
  int             totalChecks = 0;
  int             badChecks   = 0;

  always #5 clk = ~clk;

  // Ideal comparator on the currently addressed channel.
  always_comb begin
    cmp = 1'b0;
    if (int'(ch) < NCH) begin
      cmp = (analog[ch] >= dac);
    end
  end

  sar_ctrl_mc #(.WIDTH(W), .NCH(NCH), .SAMPLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
`ifdef SAR_SCAN_EN
    .scan      (scan),
`endif
    .ch_sel    (ch_sel),
    .cmp       (cmp),
    .sample    (sample),
    .ch        (ch),
    .dac       (dac),
    .busy      (busy),
    .eoc       (eoc),
    .result    (result),
    .result_ch (result_ch)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Request a conversion at the next edge; the caller then walks the timeline.
  task automatic applyStimulus(input logic [CHW-1:0] sel, input logic scanVal);
    @(negedge clk);
    start  = 1'b1;
    ch_sel = sel;
    scan   = scanVal;
  endtask

  // Walks SAMPLE, CONV and DONE of one conversion on channel expCh.
  task automatic convCycles(input int expCh, input bit holdStart);
    logic [W-1:0] tgt;
    int           i;
    int           partial;
    tgt = analog[expCh];
    for (int n = 1; n <= SC + W + 1; n++) begin
      @(negedge clk);
      if (n == 1 && !holdStart) begin
        start  = 1'b0;
        ch_sel = CHW'($urandom);
        scan   = 1'($urandom_range(0, 1));
      end
      if (n == SC + W + 1) begin
        expResult   = tgt;
        expResultCh = CHW'(expCh);
      end
      checkOutput("busy", 32'(busy), 32'd1);
      checkOutput("sample", 32'(sample), (n <= SC) ? 32'd1 : 32'd0);
      checkOutput("eoc", 32'(eoc), (n == SC + W + 1) ? 32'd1 : 32'd0);
      checkOutput("ch", 32'(ch), 32'(expCh));
      checkOutput("result", 32'(result), 32'(expResult));
      checkOutput("result_ch", 32'(result_ch), 32'(expResultCh));
      if (n <= SC) begin
        checkOutput("dac_sample", 32'(dac), 32'd0);
      end else if (n <= SC + W) begin
        i = n - SC - 1;
        partial = (int'(tgt) >> (W - i)) << (W - i);
        checkOutput("dac_conv", 32'(dac), 32'(partial | (1 << (W - 1 - i))));
      end
    end
  endtask

  task automatic idleCheck(input string tag);
    @(negedge clk);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_eoc"}, 32'(eoc), 32'd0);
    checkOutput({tag, "_sample"}, 32'(sample), 32'd0);
    checkOutput({tag, "_dac"}, 32'(dac), 32'd0);
    checkOutput({tag, "_result"}, 32'(result), 32'(expResult));
    checkOutput({tag, "_result_ch"}, 32'(result_ch), 32'(expResultCh));
  endtask

  task automatic runSingle(input logic [CHW-1:0] sel);
    int effCh;
    effCh = (int'(sel) >= NCH) ? NCH - 1 : int'(sel);
    applyStimulus(sel, 1'b0);
    convCycles(effCh, 1'b0);
    idleCheck("after_single");
  endtask

  // Runs into the 4th CONV cycle, then asserts abort (or reset) there.
  task automatic interruptConv(input bit useReset);
    applyStimulus(CHW'(1), 1'b0);
    for (int n = 1; n <= SC + 4; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
      end
    end
    if (useReset) begin
      rst_n       = 1'b0;
      expResult   = '0;
      expResultCh = '0;
    end else begin
      abort = 1'b1;
    end
    idleCheck(useReset ? "reset_mid" : "abort_mid");
    checkOutput("ch_after_interrupt", 32'(ch), useReset ? 32'd0 : 32'd1);
    rst_n = 1'b1;
    abort = 1'b0;
    repeat (3) idleCheck("after_interrupt");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int c = 0; c < NCH; c++) begin
      analog[c] = W'($urandom);
    end

    repeat (3) @(negedge clk);
    checkOutput("rst_sample", 32'(sample), 32'd0);
    checkOutput("rst_ch", 32'(ch), 32'd0);
    checkOutput("rst_dac", 32'(dac), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_eoc", 32'(eoc), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_result_ch", 32'(result_ch), 32'd0);
    rst_n = 1'b1;
    idleCheck("idle");

    $display("[TB] directed 0xA5 on channel 2");
    analog[2] = 8'hA5;
    runSingle(CHW'(2));

    $display("[TB] boundary codes and channel clamp");
    analog[1] = 8'h00;
    runSingle(CHW'(1));
    analog[4] = 8'hFF;
    runSingle(CHW'(7));
    analog[4] = 8'h01;
    runSingle(CHW'(5));

    $display("[TB] random single conversions");
    for (int k = 0; k < 8; k++) begin
      logic [CHW-1:0] sel;
      sel = CHW'($urandom);
      analog[(int'(sel) >= NCH) ? NCH - 1 : int'(sel)] = W'($urandom);
      runSingle(sel);
    end

    $display("[TB] start held high across a conversion");
    analog[0] = W'($urandom);
    applyStimulus(CHW'(0), 1'b0);
    convCycles(0, 1'b1);
    idleCheck("held_idle");
    convCycles(0, 1'b0);
    idleCheck("held_after");

`ifdef SAR_SCAN_EN
    $display("[TB] scan of all channels");
    for (int c = 0; c < NCH; c++) begin
      analog[c] = W'(8'h11 * (c + 1));
    end
    applyStimulus(CHW'($urandom), 1'b1);
    for (int c = 0; c < NCH; c++) begin
      convCycles(c, 1'b0);
    end
    idleCheck("after_scan");
`endif

    $display("[TB] abort in IDLE with start high");
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    idleCheck("abort_idle");
    start = 1'b0;
    abort = 1'b0;

    $display("[TB] abort and reset during CONV");
    interruptConv(1'b0);
    interruptConv(1'b1);

    analog[3] = W'($urandom);
    runSingle(CHW'(3));

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
